bsg_rr_arb_mux_width_p28_els_p2: RTL
====================================

BSG_RR_ARB_MUX_WIDTH_P28_ELS_P2 -- requirements
Module: bsg_rr_arb_mux_width_p28_els_p2

Interface
REQ-001 SHALL have parameter: width_p, 28, payload width per requester.
REQ-002 SHALL have parameter: els_p, 2, requester count; only 2 supported.
REQ-003 SHALL have port: clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port: reset_n_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: v_i  input  2  per-requester valid.
REQ-006 SHALL have port: data_i  input  2*width_p  payloads; requester k at bits [k*width_p +: width_p].
REQ-007 SHALL have port: last_i  input  2  per-requester final beat of a burst.
REQ-008 SHALL have port: yumi_o  output  2  one-hot (or zero) accept strobe per requester.
REQ-009 SHALL have port: v_o  output  1  output beat valid.
REQ-010 SHALL have port: data_o  output  width_p  output payload.
REQ-011 SHALL have port: sel_one_hot_o  output  2  source of the beat on data_o, one-hot.
REQ-012 SHALL have port: last_o  output  1  beat on data_o is a burst's last beat.
REQ-013 SHALL have port: ready_i  input  1  consumer accepts the beat when v_o & ready_i.

Function
REQ-014 SHALL hold one output register (v_o, data_o, sel_one_hot_o, last_o).
- Output register "free" = !v_o | ready_i.
REQ-015 SHALL set yumi_o[k] only when v_i[k], free, and k is the grant.
- At most one yumi_o bit high per cycle.
- yumi_o combinational from v_i, state, ready_i.
- No combinational path from data_i to yumi_o.
REQ-016 On yumi_o[k], SHALL load the output register next edge:
- data_o = requester k slice.
- sel_one_hot_o = 1<<k.
- last_o = last_i[k].
- v_o = 1.
- Latency: exactly 1 cycle from accept to v_o.
REQ-017 When free and no yumi, SHALL clear v_o next edge; data_o/sel_one_hot_o/last_o hold their values.
REQ-018 When v_o & !ready_i, SHALL hold all outputs stable; yumi_o = 0.
REQ-019 SHALL implement FSM {UNLOCKED, LOCKED0, LOCKED1}.
REQ-020 UNLOCKED grant:
- One requester valid: grant it.
- Both valid: grant !last_r, where last_r is the most recent granted index.
REQ-021 LOCKEDk grant: only requester k; other requester SHALL NOT be granted even if valid.
REQ-022 FSM transitions, on yumi_o[k] only:
- last_i[k]=0: go to LOCKEDk.
- last_i[k]=1: go to UNLOCKED.
- No yumi: state unchanged.
REQ-023 SHALL update last_r to k on every yumi_o[k].
- Round-robin fairness applies per burst.
- Single-beat bursts (last_i=1) alternate.
REQ-024 Requester k in LOCKEDk with v_i[k]=0: SHALL stall (no grant, no output beat) until v_i[k] returns.
REQ-025 Pass-through: beat accepted same cycle as prior beat drains (v_o & ready_i & yumi) SHALL sustain 1 beat/cycle.
REQ-026 SHALL NOT read data_i/last_i bits of an unselected requester into state.

Reset
REQ-027 reset_n_i=0 SHALL immediately, without a clock edge, force:
- v_o=0, sel_one_hot_o=0, last_o=0, data_o=0.
- FSM=UNLOCKED, last_r=1 (requester 0 wins first tie).
REQ-028 While reset_n_i=0, SHALL hold yumi_o=0.
REQ-029 Reset deassertion mid-burst SHALL begin UNLOCKED; any partially sent burst is discarded.

Verification
REQ-030 Out of reset, v_i=11, last_i=11, ready_i=1 held:
- yumi_o = 01,10,01,10...
- sel_one_hot_o lags yumi_o by 1 cycle.
- Output 1 beat/cycle.
REQ-031 Requester 0 sends 3-beat burst 0xA,0xB,0xC (last on 0xC) with v_i[1]=1 throughout:
- data_o = A,B,C then requester 1 beat.
- yumi_o[1]=0 until the cycle after 0xC is accepted.
REQ-032 ready_i=0 for 4 cycles with v_o=1, data_o=0x1234567:
- data_o, sel_one_hot_o stable.
- yumi_o=00.
- Beat accepted on the first cycle ready_i returns; next beat appears the following cycle.
REQ-033 LOCKED1 after a non-last beat, then v_i[1]=0 for 3 cycles while v_i[0]=1:
- No yumi_o[0].
- v_o drops once drained.
- Burst resumes when v_i[1]=1.
REQ-034 Assert reset_n_i=0 asynchronously mid-burst with v_o=1:
- v_o=0, yumi_o=0 before the next clock edge.
- After release with v_i=11, last_i=11: first grant is requester 0.
REQ-035 Random v_i/last_i/ready_i for 10k cycles against a scoreboard:
- No lost, duplicated, or reordered beats per requester.
- No interleaving inside a burst.
- yumi_o never 11.

Source files
------------

// File: rtl/bsg_rr_arb_mux_width_p28_els_p2.sv
// bsg_rr_arb_mux_width_p28_els_p2: burst-aware round-robin arbiter muxing two requesters into one registered output
module bsg_rr_arb_mux_width_p28_els_p2 #(
  parameter int width_p = 28,
  parameter int els_p   = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [els_p-1:0]         v_i,
  input  logic [els_p*width_p-1:0] data_i,
  input  logic [els_p-1:0]         last_i,
  output logic [els_p-1:0]         yumi_o,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  output logic [els_p-1:0]         sel_one_hot_o,
  output logic                     last_o,
  input  logic                     ready_i
);
  typedef enum logic [1:0] {UNLOCKED, LOCKED0, LOCKED1} state_e;
  state_e state_r, state_n;
  logic last_r;
  logic free;
  logic [1:0] gnt;
  assign free = !v_o | ready_i;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state_r <= UNLOCKED;
      last_r  <= 1'b1;
    end else begin
      state_r <= state_n;
      if (|yumi_o) last_r <= yumi_o[1];
    end
  always_comb
    state_n = yumi_o[0] ? (last_i[0] ? UNLOCKED : LOCKED0) :
              yumi_o[1] ? (last_i[1] ? UNLOCKED : LOCKED1) : state_r;
  // a locked burst owner is the only candidate, even while it is idle
  always_comb begin
    gnt = state_r == LOCKED0 ? {1'b0, v_i[0]} :
          state_r == LOCKED1 ? {v_i[1], 1'b0} :
          v_i == 2'b11       ? (last_r ? 2'b01 : 2'b10) : v_i;
    yumi_o = (reset_n_i && free) ? gnt : 2'b00;
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      v_o           <= 1'b0;
      data_o        <= '0;
      sel_one_hot_o <= '0;
      last_o        <= 1'b0;
    end else if (free) begin
      v_o <= |yumi_o;
      if (|yumi_o) begin
        data_o        <= yumi_o[1] ? data_i[width_p +: width_p] : data_i[0 +: width_p];
        sel_one_hot_o <= yumi_o;
        last_o        <= yumi_o[1] ? last_i[1] : last_i[0];
      end
    end
endmodule
